// File: rtl/neurosync_pkg.sv
// ---------------------------------------------------------------------------
// neurosync_pkg
// Shared constants and helpers for the neurosync input-conditioning slice.
//   N_CANAIS / N_BOTOES : total conditioned channels / play-button channels
//   CH_*                : channel index of each command button
//   DEBOUNCE_CYCLES_DEFAULT : 1 ms stability window at 50 MHz
//   classe_jogada_t     : outcome of evaluating the play buttons on an edge
//   conta_uns()         : popcount of the play-button vector
//   classifica_jogada() : maps (any rise, stable levels) to a play outcome
// ---------------------------------------------------------------------------
package neurosync_pkg;

  localparam int N_CANAIS = 8;
  localparam int N_BOTOES = 4;

  // Channels 0..3 are the play buttons; the commands follow in this order.
  localparam int CH_MAIS     = 4;
  localparam int CH_MENOS    = 5;
  localparam int CH_CONFIRMA = 6;
  localparam int CH_JOGAR    = 7;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

  typedef enum logic [1:0] {
    JOGADA_NENHUMA,
    JOGADA_VALIDA,
    JOGADA_MULTIPLA
  } classe_jogada_t;

  function automatic logic [2:0] conta_uns(input logic [N_BOTOES-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < N_BOTOES; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // A play is only evaluated on an edge where some play button rose; the
  // stable levels after that edge decide whether it is a single press or an
  // ambiguous one (simultaneous rise, or a second button while one is held).
  function automatic classe_jogada_t classifica_jogada(
    input logic                subiu,
    input logic [N_BOTOES-1:0] botoes
  );
    classe_jogada_t c;
    logic [2:0]     n;
    n = conta_uns(botoes);
    c = JOGADA_NENHUMA;
    if (subiu) begin
      if (n == 3'd1) begin
        c = JOGADA_VALIDA;
      end else if (n > 3'd1) begin
        c = JOGADA_MULTIPLA;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/debounce_canal.sv
// ---------------------------------------------------------------------------
// debounce_canal
// One conditioned input: 2-FF synchronizer, stability counter, stable level
// register and a one-cycle rising-edge pulse.
//   clock, reset : system clock, synchronous active-high reset
//   raw          : asynchronous button level, active-high
//   st           : debounced stable level (registered)
//   rise         : one-cycle pulse on a debounced 0->1 transition (registered)
//   st_next      : value st takes on the coming edge
//   rise_next    : value rise takes on the coming edge
// The *_next outputs let the top react on the same edge the level commits,
// so downstream registers add no extra cycle of latency.
// ---------------------------------------------------------------------------
module debounce_canal
  import neurosync_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic st,
  output logic rise,
  output logic st_next,
  output logic rise_next
);

  // DEBOUNCE_CYCLES must be at least 1; the counter is sized to hold it.
  localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Two flops bring the asynchronous level into the clock domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  // Any return of s to st restarts the count, so bounces never accumulate;
  // the count stops at LIMITE and commits, so it can never wrap.
  always_comb begin
    st_next   = st;
    cnt_next  = cnt;
    rise_next = 1'b0;
    if (s == st) begin
      cnt_next = '0;
    end else if (cnt == LIMITE) begin
      st_next   = s;
      cnt_next  = '0;
      rise_next = s;
    end else begin
      cnt_next = cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st   <= 1'b0;
      cnt  <= '0;
      rise <= 1'b0;
    end else begin
      st   <= st_next;
      cnt  <= cnt_next;
      rise <= rise_next;
    end
  end

endmodule

// File: rtl/condiciona_entradas.sv
// ---------------------------------------------------------------------------
// condiciona_entradas
// Conditions the eight raw board inputs for the neurosync core.
//   clock, reset       : system clock, synchronous active-high reset
//   botoes_raw[3:0]    : asynchronous play buttons
//   mais_raw, menos_raw, confirma_raw, jogar_raw : asynchronous commands
//   limpa              : clears jogada (a simultaneous valid play wins)
//   botoes_db[3:0]     : debounced level of each play button
//   jogada[3:0]        : one-hot last valid play, held
//   tem_jogada         : one-cycle strobe when jogada is loaded
//   multi_press        : one-cycle strobe for an ambiguous play
//   mais, menos, confirma, jogar : one-cycle debounced rising-edge pulses
// ---------------------------------------------------------------------------
module condiciona_entradas
  import neurosync_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes_raw,
  input  logic                mais_raw,
  input  logic                menos_raw,
  input  logic                confirma_raw,
  input  logic                jogar_raw,
  input  logic                limpa,
  output logic [N_BOTOES-1:0] botoes_db,
  output logic [N_BOTOES-1:0] jogada,
  output logic                tem_jogada,
  output logic                multi_press,
  output logic                mais,
  output logic                menos,
  output logic                confirma,
  output logic                jogar
);

  logic [N_CANAIS-1:0] raw;
  logic [N_CANAIS-1:0] st;
  logic [N_CANAIS-1:0] rise;
  logic [N_CANAIS-1:0] st_next;
  logic [N_CANAIS-1:0] rise_next;

  logic [N_BOTOES-1:0] botoes_next;
  logic                algum_subiu;
  classe_jogada_t      classe;

  // Bits of the channel bundle this stage does not consume: command levels
  // are never exported and play pulses are used in their *_next form.
  logic                sinais_unused;

  assign raw = {jogar_raw, confirma_raw, menos_raw, mais_raw, botoes_raw};

  for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
    debounce_canal #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_canal (
      .clock    (clock),
      .reset    (reset),
      .raw      (raw[i]),
      .st       (st[i]),
      .rise     (rise[i]),
      .st_next  (st_next[i]),
      .rise_next(rise_next[i])
    );
  end

  assign botoes_db = st[N_BOTOES-1:0];
  assign mais      = rise[CH_MAIS];
  assign menos     = rise[CH_MENOS];
  assign confirma  = rise[CH_CONFIRMA];
  assign jogar     = rise[CH_JOGAR];

  assign sinais_unused = ^{st[N_CANAIS-1:N_BOTOES], rise[N_BOTOES-1:0],
                           st_next[N_CANAIS-1:N_BOTOES],
                           rise_next[N_CANAIS-1:N_BOTOES]};

  // Classify using the levels the play channels will hold after this edge,
  // so jogada and tem_jogada land together with botoes_db.
  always_comb begin
    botoes_next = st_next[N_BOTOES-1:0];
    algum_subiu = |rise_next[N_BOTOES-1:0];
    classe      = classifica_jogada(algum_subiu, botoes_next);
  end

  // limpa is applied first so that a valid play on the same edge overrides it.
  always_ff @(posedge clock) begin
    if (reset) begin
      jogada      <= '0;
      tem_jogada  <= 1'b0;
      multi_press <= 1'b0;
    end else begin
      tem_jogada  <= 1'b0;
      multi_press <= 1'b0;
      if (limpa) begin
        jogada <= '0;
      end
      case (classe)
        JOGADA_VALIDA: begin
          jogada     <= botoes_next;
          tem_jogada <= 1'b1;
        end
        JOGADA_MULTIPLA: begin
          multi_press <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_condiciona_entradas.sv
// ---------------------------------------------------------------------------
// tb_condiciona_entradas
// Directed bench for condiciona_entradas with DEBOUNCE_CYCLES = 4. Each
// stimulus queues the pulse it should cause (kind, cycle, jogada, botoes_db);
// a monitor pops an entry whenever any pulse output is high.
// ---------------------------------------------------------------------------
module tb_condiciona_entradas;

  localparam int D = 4;
  // Inputs change between edges; the next edge is edge 0 and the pulse is
  // visible after edge D+1, i.e. D+2 cycle-counter increments later.
  localparam int LAT = D + 2;

  localparam logic [5:0] P_TEM   = 6'b100000;
  localparam logic [5:0] P_MULTI = 6'b010000;
  localparam logic [5:0] P_MAIS  = 6'b001000;
  localparam logic [5:0] P_CONF  = 6'b000010;
  localparam logic [5:0] P_JOGAR = 6'b000001;

  typedef struct {
    logic [5:0] pulsos;
    int         ciclo;
    logic [3:0] jogada;
    logic [3:0] db;
  } evento_t;

  logic       clock;
  logic       reset;
  logic [3:0] botoes_raw;
  logic       mais_raw;
  logic       menos_raw;
  logic       confirma_raw;
  logic       jogar_raw;
  logic       limpa;
  logic [3:0] botoes_db;
  logic [3:0] jogada;
  logic       tem_jogada;
  logic       multi_press;
  logic       mais;
  logic       menos;
  logic       confirma;
  logic       jogar;

  evento_t fila[$];
  int      ciclo  = 0;
  int      testes = 0;
  int      falhas = 0;

  condiciona_entradas #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .botoes_raw  (botoes_raw),
    .mais_raw    (mais_raw),
    .menos_raw   (menos_raw),
    .confirma_raw(confirma_raw),
    .jogar_raw   (jogar_raw),
    .limpa       (limpa),
    .botoes_db   (botoes_db),
    .jogada      (jogada),
    .tem_jogada  (tem_jogada),
    .multi_press (multi_press),
    .mais        (mais),
    .menos       (menos),
    .confirma    (confirma),
    .jogar       (jogar)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) ciclo <= ciclo + 1;

  task automatic check_output(input string nome, input logic [31:0] atual,
                              input logic [31:0] esperado);
    testes++;
    if (atual !== esperado) begin
      falhas++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
               nome, atual, esperado, ciclo);
    end
  endtask

  task automatic espera(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Queue the pulse that the stimulus just applied should produce.
  task automatic apply_stimulus(input logic [5:0] pulsos, input int atraso,
                                input logic [3:0] jog, input logic [3:0] db);
    evento_t e;
    e.pulsos = pulsos;
    e.ciclo  = ciclo + atraso;
    e.jogada = jog;
    e.db     = db;
    fila.push_back(e);
  endtask

  // Any pulse output going high consumes one expected entry.
  always @(negedge clock) begin
    logic [5:0] p;
    evento_t    e;
    p = {tem_jogada, multi_press, mais, menos, confirma, jogar};
    if (p != 6'b0) begin
      if (fila.size() == 0) begin
        testes++;
        falhas++;
        $display("[TB] FAIL unexpected_pulse: got pulses %b at cycle %0d, expected none",
                 p, ciclo);
      end else begin
        e = fila.pop_front();
        check_output("pulse_kind", 32'(p), 32'(e.pulsos));
        check_output("pulse_cycle", ciclo, e.ciclo);
        check_output("jogada_at_pulse", 32'(jogada), 32'(e.jogada));
        check_output("botoes_db_at_pulse", 32'(botoes_db), 32'(e.db));
      end
    end
  end

  initial begin
    reset        = 1'b1;
    limpa        = 1'b0;
    botoes_raw   = 4'b0000;
    mais_raw     = 1'b0;
    menos_raw    = 1'b0;
    confirma_raw = 1'b0;
    jogar_raw    = 1'b0;

    espera(3);
    check_output("reset_jogada", 32'(jogada), 0);
    check_output("reset_botoes_db", 32'(botoes_db), 0);
    check_output("reset_pulses",
                 32'({tem_jogada, multi_press, mais, menos, confirma, jogar}), 0);
    reset = 1'b0;
    espera(2);

    // Clean press of button 2.
    botoes_raw = 4'b0100;
    apply_stimulus(P_TEM, LAT, 4'b0100, 4'b0100);
    espera(12);
    check_output("held_botoes_db", 32'(botoes_db), 32'h4);
    botoes_raw = 4'b0000;
    espera(10);
    check_output("release_jogada_held", 32'(jogada), 32'h4);
    check_output("release_botoes_db", 32'(botoes_db), 0);

    // Bouncing confirma: pulses of 2 cycles never reach the window.
    for (int k = 0; k < 6; k++) begin
      confirma_raw = (k % 2 == 0);
      espera(2);
    end
    confirma_raw = 1'b1;
    apply_stimulus(P_CONF, LAT, 4'b0100, 4'b0000);
    espera(12);
    confirma_raw = 1'b0;
    espera(10);

    // Simultaneous rise of two play buttons.
    botoes_raw = 4'b0011;
    apply_stimulus(P_MULTI, LAT, 4'b0100, 4'b0011);
    espera(10);
    check_output("multi_keeps_jogada", 32'(jogada), 32'h4);
    botoes_raw = 4'b0000;
    espera(10);
    botoes_raw = 4'b1000;
    apply_stimulus(P_TEM, LAT, 4'b1000, 4'b1000);
    espera(10);
    botoes_raw = 4'b0000;
    espera(10);

    // Second button pressed while the first is still held.
    botoes_raw = 4'b0001;
    apply_stimulus(P_TEM, LAT, 4'b0001, 4'b0001);
    espera(10);
    botoes_raw = 4'b0011;
    apply_stimulus(P_MULTI, LAT, 4'b0001, 4'b0011);
    espera(10);
    botoes_raw = 4'b0000;
    espera(10);

    // Long hold of jogar: a single pulse, nothing on release.
    jogar_raw = 1'b1;
    apply_stimulus(P_JOGAR, LAT, 4'b0001, 4'b0000);
    espera(100);
    jogar_raw = 1'b0;
    espera(10);
    check_output("hold_botoes_db", 32'(botoes_db), 0);

    // Reset on edge 3 of a mais press; the press restarts afterwards.
    mais_raw = 1'b1;
    espera(3);
    reset = 1'b1;
    espera(1);
    check_output("midreset_jogada", 32'(jogada), 0);
    check_output("midreset_botoes_db", 32'(botoes_db), 0);
    check_output("midreset_pulses",
                 32'({tem_jogada, multi_press, mais, menos, confirma, jogar}), 0);
    reset = 1'b0;
    apply_stimulus(P_MAIS, LAT, 4'b0000, 4'b0000);
    espera(10);
    mais_raw = 1'b0;
    espera(10);

    // limpa alone clears a held play.
    botoes_raw = 4'b0010;
    apply_stimulus(P_TEM, LAT, 4'b0010, 4'b0010);
    espera(10);
    botoes_raw = 4'b0000;
    espera(10);
    check_output("before_limpa_jogada", 32'(jogada), 32'h2);
    limpa = 1'b1;
    espera(1);
    limpa = 1'b0;
    check_output("limpa_jogada", 32'(jogada), 0);

    // limpa on the very edge a valid play commits: the play wins.
    botoes_raw = 4'b0001;
    apply_stimulus(P_TEM, LAT, 4'b0001, 4'b0001);
    espera(LAT - 1);
    limpa = 1'b1;
    espera(1);
    limpa = 1'b0;
    espera(5);
    check_output("limpa_vs_play_jogada", 32'(jogada), 32'h1);
    botoes_raw = 4'b0000;
    espera(10);

    check_output("missing_pulses", fila.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule

// File: doc/condiciona_entradas.md
# condiciona_entradas

Input-conditioning stage placed directly upstream of the `neurosync` game core. It synchronizes, debounces and edge-detects the eight raw board inputs: four play buttons plus `mais`, `menos`, `confirma` and `jogar`. It delivers clean one-cycle command pulses and a registered one-hot play (`jogada`) with a `tem_jogada` strobe. Multi-button presses are rejected and flagged, so the core never sees an ambiguous play.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: cycles an input must stay stable before it is accepted (1 ms at 50 MHz); must be ≥1.
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high; clears all state.
- `botoes_raw` in 4: asynchronous play buttons, active-high.
- `mais_raw`, `menos_raw`, `confirma_raw`, `jogar_raw` in 1 each: asynchronous command buttons, active-high.
- `limpa` in 1: clears `jogada` to 0.
- `botoes_db` out 4: debounced stable level of each play button.
- `jogada` out 4: one-hot code of the last valid play; held until the next valid play or `limpa`.
- `tem_jogada` out 1: one-cycle pulse when `jogada` is loaded.
- `multi_press` out 1: one-cycle pulse when a play-button rise leaves more than one button stable-high.
- `mais`, `menos`, `confirma`, `jogar` out 1 each: one-cycle pulse on the debounced rising edge.

## Operation
- Each of the 8 channels is identical:
  - 2-FF synchronizer producing `s`.
  - Stable register `st`.
  - Counter `cnt`, width $clog2(DEBOUNCE_CYCLES+1).
- Channel update on each edge:
  - If `s == st`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `st <= s` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
- Bounce handling: any return of `s` to `st` restarts the count from 0. The counter never wraps.
- Rise pulse is a register set on the same edge that `st` goes 0→1 and cleared on the next edge. A falling `st` produces no pulse.
- Command outputs (`mais`, `menos`, `confirma`, `jogar`) are the rise pulses of channels 4–7.
- Play logic runs on any edge where at least one play channel rises. It evaluates the post-update `st[3:0]`:
  - popcount == 1: `jogada <= st[3:0]` and pulse `tem_jogada`.
  - popcount > 1: pulse `multi_press`; `jogada` is unchanged and `tem_jogada` stays low.
- Simultaneous rises on two play channels in the same cycle are a `multi_press`.
- Pressing a second button while the first is still held is also a `multi_press`.
- `limpa` sets `jogada <= 0`. If `limpa` coincides with a valid play, the play wins.
- Command channels never affect `jogada` or `multi_press`.

## Timing
- Reset value of every output: 0. Reset also clears all synchronizers, `st`, `cnt` and pulse registers.
- Latency: edge 0 is the first edge that samples a raw input high, with the input stable from then on.
  - `st` and the rise pulse are high after edge DEBOUNCE_CYCLES+1.
  - The pulse is low again after edge DEBOUNCE_CYCLES+2.
  - `jogada` and `tem_jogada` follow the same timing, with no extra cycle.
- Release latency is identical, but produces no pulse.
- Reset mid-count: the count is discarded. An input held through reset is treated as a new press: one pulse at DEBOUNCE_CYCLES+1 edges after the first non-reset edge.
- Holding an input indefinitely yields exactly one pulse.

## Structure
- Shared package `neurosync_pkg` holds:
  - `N_CANAIS = 8` and `N_BOTOES = 4`.
  - Channel index constants `CH_MAIS = 4`, `CH_MENOS = 5`, `CH_CONFIRMA = 6`, `CH_JOGAR = 7`.
  - Default `DEBOUNCE_CYCLES`.
- Sub-module `debounce_canal` (synchronizer + counter + `st` + rise pulse) is instantiated 8 times via generate.
- The top-level holds the play/popcount logic and the `jogada` register.

## Test plan
Bench uses `DEBOUNCE_CYCLES = 4`.
- **Clean press:** `botoes_raw = 4'b0100` from edge 0 → `tem_jogada = 1` only after edge 5, `jogada = 4'b0100`, `botoes_db[2] = 1`, `multi_press = 0`.
- **Bounce:** `confirma_raw` toggles every 2 cycles for 12 cycles, then holds 1 → no `confirma` pulse during the bounce; exactly one pulse 5 edges after the last toggle.
- **Simultaneous plays:**
  - `botoes_raw` 0→`4'b0011` in one cycle → one `multi_press` pulse, no `tem_jogada`, `jogada` keeps its prior value.
  - Then press `4'b1000` alone after release → `jogada = 4'b1000`.
- **Hold:** `jogar_raw` held for 100 cycles, then released → exactly one `jogar` pulse; no pulse on release; `botoes_db` unaffected.
- **Reset mid-count:** `mais_raw` rises, `reset` asserted at edge 3 for 1 cycle with input still high → all outputs 0 during reset; `mais` pulses 5 edges after the first non-reset edge.
- **`limpa` vs play:**
  - `limpa` alone → `jogada = 0`.
  - `limpa` on the same edge as a valid play of `4'b0001` → `jogada = 4'b0001` and `tem_jogada = 1`.
